// File: rtl/kernel_rowbuf_ctrl.sv
// Sequencing controller for a KERNEL_SIZE x KERNEL_SIZE window over KERNEL_SIZE-1 row buffers.
// Rotates a write pointer across the buffers and frames the border-trimmed output stream.
`timescale 1ns/1ps

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        8
`define DTYPE_FRAME_START  8'h01
`define DTYPE_FRAME_END    8'h02
`define DTYPE_ROW_START    8'h04
`define DTYPE_ROW_END      8'h08
`define DTYPE_PIXEL_MASK   8'h70
`define DTYPE_HEADER       8'h80
`endif

module kernel_rowbuf_ctrl #(
    parameter int KERNEL_SIZE    = 3,
    parameter int NUM_COLS_WIDTH = 11,
    parameter int MAX_COLS       = 1288,
    parameter int NUM_ROWS_WIDTH = 11
) (
    input  logic                      clk,
    input  logic                      resetb,
    input  logic                      dvi,
    input  logic [`DTYPE_WIDTH-1:0]   dtypei,
    input  logic                      clr_err,
    output logic [NUM_COLS_WIDTH-1:0] col_addr,
    output logic [KERNEL_SIZE-2:0]    buf_we,
    output logic [2:0]                rd_base,
    output logic                      kernel_shift,
    output logic                      dvo,
    output logic [`DTYPE_WIDTH-1:0]   dtypeo,
    output logic [NUM_COLS_WIDTH-1:0] out_cols,
    output logic [NUM_ROWS_WIDTH-1:0] out_rows,
    output logic                      err_overflow,
    output logic                      err_len,
    output logic                      err_proto,
    output logic [1:0]                state_dbg
);

    localparam int NBUF = KERNEL_SIZE - 1;
    localparam logic [NUM_COLS_WIDTH-1:0] MAX_COLS_V = NUM_COLS_WIDTH'(MAX_COLS);
    localparam logic [NUM_COLS_WIDTH-1:0] TRIM_C     = NUM_COLS_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [NUM_ROWS_WIDTH-1:0] TRIM_R     = NUM_ROWS_WIDTH'(KERNEL_SIZE - 1);
    localparam logic [2:0]                LAST_PTR   = 3'(NBUF - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GAP  = 2'd1,
        S_ROW  = 2'd2
    } state_t;

    state_t                    state;
    logic [2:0]                wr_ptr;
    logic [NUM_ROWS_WIDTH-1:0] row_cnt;
    logic [NUM_COLS_WIDTH-1:0] row0_len;

    logic is_pix, is_fs, is_fe, is_rs, is_re;
    logic in_row, pix_acc, col_ok, valid_row, valid_col, dvo_nx;

    // Handshake: there is no backpressure; a token is consumed in every cycle where dvi=1.
    assign is_pix    = |(dtypei & `DTYPE_PIXEL_MASK);
    assign is_fs     = (dtypei == `DTYPE_FRAME_START);
    assign is_fe     = (dtypei == `DTYPE_FRAME_END);
    assign is_rs     = (dtypei == `DTYPE_ROW_START);
    assign is_re     = (dtypei == `DTYPE_ROW_END);
    assign in_row    = (state == S_ROW);
    assign pix_acc   = dvi && is_pix && in_row;
    assign col_ok    = (col_addr < MAX_COLS_V);
    assign valid_row = (row_cnt >= TRIM_R);
    assign valid_col = (col_addr >= TRIM_C);

    assign kernel_shift = pix_acc;
    assign rd_base      = wr_ptr;
    assign state_dbg    = state;

    always_comb begin
        buf_we = '0;
        for (int i = 0; i < NBUF; i++) begin
            if (wr_ptr == 3'(i)) buf_we[i] = pix_acc && col_ok;
        end
    end

    // Tokens that are ignored as protocol violations keep plain dvi framing.
    always_comb begin
        dvo_nx = dvi;
        if (is_pix && in_row)
            dvo_nx = dvi && valid_row && valid_col;
        else if (is_rs && (state != S_IDLE))
            dvo_nx = dvi && valid_row;
        else if (is_re && in_row)
            dvo_nx = dvi && valid_row;
    end

    always_ff @(posedge clk) begin
        if (!resetb) begin
            state        <= S_IDLE;
            col_addr     <= '0;
            wr_ptr       <= '0;
            row_cnt      <= '0;
            row0_len     <= '0;
            dvo          <= 1'b0;
            dtypeo       <= '0;
            out_cols     <= '0;
            out_rows     <= '0;
            err_overflow <= 1'b0;
            err_len      <= 1'b0;
            err_proto    <= 1'b0;
        end else begin
            dtypeo <= dtypei;
            dvo    <= dvo_nx;
            // A clear is overridden by a set in the same cycle below.
            if (clr_err) begin
                err_overflow <= 1'b0;
                err_len      <= 1'b0;
                err_proto    <= 1'b0;
            end
            if (dvi) begin
                if (is_pix) begin
                    if (in_row) begin
                        if (col_ok) col_addr <= col_addr + 1'b1;
                        else        err_overflow <= 1'b1;
                    end else begin
                        err_proto <= 1'b1;
                    end
                end else if (is_fs) begin
                    if (state != S_IDLE) err_proto <= 1'b1;
                    state   <= S_GAP;
                    row_cnt <= '0;
                    wr_ptr  <= '0;
                end else if (is_rs) begin
                    if (state == S_IDLE) begin
                        err_proto <= 1'b1;
                    end else begin
                        if (in_row) err_proto <= 1'b1;
                        state    <= S_ROW;
                        col_addr <= '0;
                    end
                end else if (is_re) begin
                    if (in_row) begin
                        state  <= S_GAP;
                        wr_ptr <= (wr_ptr == LAST_PTR) ? 3'd0 : wr_ptr + 3'd1;
                        if (row_cnt != '1) row_cnt <= row_cnt + 1'b1;
                        if (row_cnt == '0)
                            row0_len <= col_addr;
                        else if (col_addr != row0_len)
                            err_len <= 1'b1;
                    end else begin
                        err_proto <= 1'b1;
                    end
                end else if (is_fe) begin
                    if (state == S_GAP) begin
                        state    <= S_IDLE;
                        out_cols <= (row0_len > TRIM_C) ? row0_len - TRIM_C : '0;
                        out_rows <= (row_cnt > TRIM_R) ? row_cnt - TRIM_R : '0;
                    end else begin
                        err_proto <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
            end
        end
    end

endmodule

// File: tb/tb_kernel_rowbuf_ctrl.sv
// Scenario bench for kernel_rowbuf_ctrl (K=3, row buffers 8 deep).
// Expected {dvo,dtypeo} is queued when a token is driven and checked one edge later.
`timescale 1ns/1ps

`ifndef DTYPE_WIDTH
`define DTYPE_WIDTH        8
`define DTYPE_FRAME_START  8'h01
`define DTYPE_FRAME_END    8'h02
`define DTYPE_ROW_START    8'h04
`define DTYPE_ROW_END      8'h08
`define DTYPE_PIXEL_MASK   8'h70
`define DTYPE_HEADER       8'h80
`endif

module tb_kernel_rowbuf_ctrl;

    localparam int K    = 3;
    localparam int NB   = K - 1;
    localparam int CW   = 11;
    localparam int RW   = 11;
    localparam int MAXC = 8;

    localparam logic [7:0] FS  = `DTYPE_FRAME_START;
    localparam logic [7:0] FE  = `DTYPE_FRAME_END;
    localparam logic [7:0] RS  = `DTYPE_ROW_START;
    localparam logic [7:0] RE  = `DTYPE_ROW_END;
    localparam logic [7:0] PIX = 8'h10;
    localparam logic [7:0] HDR = `DTYPE_HEADER;

    logic          clk = 1'b0;
    logic          resetb, dvi, clr_err;
    logic [7:0]    dtypei;
    logic [CW-1:0] col_addr;
    logic [NB-1:0] buf_we;
    logic [2:0]    rd_base;
    logic          kernel_shift, dvo;
    logic [7:0]    dtypeo;
    logic [CW-1:0] out_cols;
    logic [RW-1:0] out_rows;
    logic          err_overflow, err_len, err_proto;
    logic [1:0]    state_dbg;

    logic [8:0] exp_q[$];
    logic [8:0] mon_exp;
    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    kernel_rowbuf_ctrl #(
        .KERNEL_SIZE(K), .NUM_COLS_WIDTH(CW), .MAX_COLS(MAXC), .NUM_ROWS_WIDTH(RW)
    ) dut (
        .clk(clk), .resetb(resetb), .dvi(dvi), .dtypei(dtypei), .clr_err(clr_err),
        .col_addr(col_addr), .buf_we(buf_we), .rd_base(rd_base),
        .kernel_shift(kernel_shift), .dvo(dvo), .dtypeo(dtypeo),
        .out_cols(out_cols), .out_rows(out_rows),
        .err_overflow(err_overflow), .err_len(err_len), .err_proto(err_proto),
        .state_dbg(state_dbg)
    );

    // Scoreboard: each queued entry is the framing result of one driven cycle.
    always @(posedge clk) begin
        #1;
        if (exp_q.size() > 0) begin
            mon_exp = exp_q.pop_front();
            total++;
            if ({dvo, dtypeo} !== mon_exp) begin
                bad++;
                $display("FAIL sb_dvo_dtypeo t=%0t act=%b/%h exp=%b/%h",
                         $time, dvo, dtypeo, mon_exp[8], mon_exp[7:0]);
            end
        end
    end

    task automatic send(input logic dv, input logic [7:0] dt, input logic clr,
                        input logic e_dvo, input logic e_ks, input logic [NB-1:0] e_we);
        @(negedge clk);
        dvi = dv; dtypei = dt; clr_err = clr;
        #1;
        total++;
        if (kernel_shift !== e_ks) begin
            bad++;
            $display("FAIL kernel_shift t=%0t dt=%h act=%b exp=%b", $time, dt, kernel_shift, e_ks);
        end
        total++;
        if (buf_we !== e_we) begin
            bad++;
            $display("FAIL buf_we t=%0t dt=%h act=%b exp=%b", $time, dt, buf_we, e_we);
        end
        exp_q.push_back({e_dvo, dt});
    endtask

    task automatic idle();
        send(1'b0, 8'h00, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic clear_errs();
        send(1'b0, 8'h00, 1'b1, 1'b0, 1'b0, '0);
        idle();
    endtask

    // r is the row index within the frame; rows below K-1 and columns below K-1 are trimmed.
    task automatic drive_row(input int r, input int n, input logic [NB-1:0] we);
        logic vr;
        vr = (r >= K - 1);
        send(1'b1, RS, 1'b0, vr, 1'b0, '0);
        for (int c = 0; c < n; c++)
            send(1'b1, PIX, 1'b0, vr && (c >= K - 1), 1'b1, (c < MAXC) ? we : '0);
        send(1'b1, RE, 1'b0, vr, 1'b0, '0);
    endtask

    task automatic do_reset(input int n);
        @(negedge clk);
        resetb = 1'b0; dvi = 1'b0; dtypei = 8'h00; clr_err = 1'b0;
        repeat (n) @(negedge clk);
        resetb = 1'b1;
        #1;
    endtask

    task automatic check_dims(input string name, input logic [CW-1:0] ec, input logic [RW-1:0] er);
        total++;
        if (out_cols !== ec) begin
            bad++;
            $display("FAIL %s_out_cols act=%0d exp=%0d", name, out_cols, ec);
        end
        total++;
        if (out_rows !== er) begin
            bad++;
            $display("FAIL %s_out_rows act=%0d exp=%0d", name, out_rows, er);
        end
    endtask

    task automatic test_reset();
        do_reset(2);
        total++;
        if ({dvo, dtypeo, col_addr, rd_base, out_cols, out_rows, err_overflow, err_len,
             err_proto, state_dbg, buf_we, kernel_shift} !== '0) begin
            bad++;
            $display("FAIL reset_state act=col%0d st%0d dvo%b errs%b%b%b exp=all zero",
                     col_addr, state_dbg, dvo, err_overflow, err_len, err_proto);
        end
    endtask

    task automatic test_frame();
        send(1'b1, FS, 1'b0, 1'b1, 1'b0, '0);
        drive_row(0, 5, 2'b01);
        idle();
        total++;
        if (rd_base !== 3'd1) begin
            bad++;
            $display("FAIL frame_rd_base act=%0d exp=1", rd_base);
        end
        drive_row(1, 5, 2'b10);
        send(1'b1, HDR, 1'b0, 1'b1, 1'b0, '0);
        drive_row(2, 5, 2'b01);
        drive_row(3, 5, 2'b10);
        send(1'b1, FE, 1'b0, 1'b1, 1'b0, '0);
        idle();
        check_dims("frame", 11'd3, 11'd2);
        total++;
        if ({err_overflow, err_len, err_proto, state_dbg} !== 5'b0) begin
            bad++;
            $display("FAIL frame_errs_state act=%b%b%b st%0d exp=000 st0",
                     err_overflow, err_len, err_proto, state_dbg);
        end
    endtask

    task automatic test_overflow();
        send(1'b1, FS, 1'b0, 1'b1, 1'b0, '0);
        drive_row(0, 10, 2'b01);
        idle();
        total++;
        if (col_addr !== 11'd8) begin
            bad++;
            $display("FAIL ovf_col_addr act=%0d exp=8", col_addr);
        end
        total++;
        if ({err_overflow, err_proto} !== 2'b10) begin
            bad++;
            $display("FAIL ovf_flags act=%b%b exp=10", err_overflow, err_proto);
        end
        send(1'b1, FE, 1'b0, 1'b1, 1'b0, '0);
        idle();
        check_dims("ovf", 11'd6, 11'd0);
        clear_errs();
        total++;
        if (err_overflow !== 1'b0) begin
            bad++;
            $display("FAIL ovf_clear act=%b exp=0", err_overflow);
        end
    endtask

    task automatic test_len();
        send(1'b1, FS, 1'b0, 1'b1, 1'b0, '0);
        drive_row(0, 5, 2'b01);
        drive_row(1, 5, 2'b10);
        idle();
        total++;
        if (err_len !== 1'b0) begin
            bad++;
            $display("FAIL len_early act=%b exp=0", err_len);
        end
        drive_row(2, 4, 2'b01);
        idle();
        total++;
        if (err_len !== 1'b1) begin
            bad++;
            $display("FAIL len_short_row act=%b exp=1", err_len);
        end
        send(1'b1, FE, 1'b0, 1'b1, 1'b0, '0);
        idle();
        check_dims("len", 11'd3, 11'd1);
        clear_errs();
    endtask

    task automatic test_proto();
        send(1'b1, FS, 1'b0, 1'b1, 1'b0, '0);
        drive_row(0, 2, 2'b01);
        send(1'b1, PIX, 1'b0, 1'b1, 1'b0, '0);
        idle();
        total++;
        if ({err_proto, rd_base, state_dbg} !== {1'b1, 3'd1, 2'd1}) begin
            bad++;
            $display("FAIL proto_pix_gap act=%b/%0d/%0d exp=1/1/1", err_proto, rd_base, state_dbg);
        end
        clear_errs();
        send(1'b1, RS, 1'b0, 1'b0, 1'b0, '0);
        for (int c = 0; c < 3; c++) send(1'b1, PIX, 1'b0, 1'b0, 1'b1, 2'b10);
        send(1'b1, RS, 1'b0, 1'b0, 1'b0, '0);
        send(1'b1, PIX, 1'b0, 1'b0, 1'b1, 2'b10);
        idle();
        total++;
        if ({err_proto, col_addr, rd_base, state_dbg} !== {1'b1, 11'd1, 3'd1, 2'd2}) begin
            bad++;
            $display("FAIL proto_rs_in_row act=%b/%0d/%0d/%0d exp=1/1/1/2",
                     err_proto, col_addr, rd_base, state_dbg);
        end
        send(1'b1, RS, 1'b1, 1'b0, 1'b0, '0);
        idle();
        total++;
        if (err_proto !== 1'b1) begin
            bad++;
            $display("FAIL proto_set_beats_clr act=%b exp=1", err_proto);
        end
        clear_errs();
        total++;
        if (err_proto !== 1'b0) begin
            bad++;
            $display("FAIL proto_clr act=%b exp=0", err_proto);
        end
        send(1'b1, RE, 1'b0, 1'b0, 1'b0, '0);
        send(1'b1, FE, 1'b0, 1'b1, 1'b0, '0);
        idle();
        clear_errs();
    endtask

    task automatic test_reset_mid_row();
        send(1'b1, FS, 1'b0, 1'b1, 1'b0, '0);
        send(1'b1, RS, 1'b0, 1'b0, 1'b0, '0);
        for (int c = 0; c < 3; c++) send(1'b1, PIX, 1'b0, 1'b0, 1'b1, 2'b01);
        idle();
        total++;
        if (col_addr !== 11'd3) begin
            bad++;
            $display("FAIL rst_mid_pre_col act=%0d exp=3", col_addr);
        end
        do_reset(1);
        total++;
        if ({dvo, dtypeo, col_addr, rd_base, out_cols, out_rows, err_overflow, err_len,
             err_proto, state_dbg} !== '0) begin
            bad++;
            $display("FAIL rst_mid_state act=col%0d st%0d dims%0d/%0d exp=all zero",
                     col_addr, state_dbg, out_cols, out_rows);
        end
        send(1'b1, FS, 1'b0, 1'b1, 1'b0, '0);
        drive_row(0, 3, 2'b01);
        drive_row(1, 3, 2'b10);
        drive_row(2, 3, 2'b01);
        send(1'b1, FE, 1'b0, 1'b1, 1'b0, '0);
        idle();
        check_dims("rst_mid", 11'd1, 11'd1);
    endtask

    task automatic test_restart();
        send(1'b1, FS, 1'b0, 1'b1, 1'b0, '0);
        drive_row(0, 2, 2'b01);
        send(1'b1, RS, 1'b0, 1'b0, 1'b0, '0);
        for (int c = 0; c < 2; c++) send(1'b1, PIX, 1'b0, 1'b0, 1'b1, 2'b10);
        send(1'b1, FS, 1'b0, 1'b1, 1'b0, '0);
        idle();
        total++;
        if ({err_proto, rd_base, state_dbg} !== {1'b1, 3'd0, 2'd1}) begin
            bad++;
            $display("FAIL restart_fs act=%b/%0d/%0d exp=1/0/1", err_proto, rd_base, state_dbg);
        end
        clear_errs();
        drive_row(0, 3, 2'b01);
        drive_row(1, 3, 2'b10);
        drive_row(2, 3, 2'b01);
        send(1'b1, FE, 1'b0, 1'b1, 1'b0, '0);
        idle();
        check_dims("restart", 11'd1, 11'd1);
        total++;
        if ({err_overflow, err_len, err_proto} !== 3'b000) begin
            bad++;
            $display("FAIL restart_errs act=%b%b%b exp=000", err_overflow, err_len, err_proto);
        end
    endtask

    initial begin
        resetb = 1'b0; dvi = 1'b0; dtypei = 8'h00; clr_err = 1'b0;
        test_reset();
        test_frame();
        test_overflow();
        test_len();
        test_proto();
        test_reset_mid_row();
        test_restart();
        idle();
        @(posedge clk);
        #2;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL sb_drain act=%0d exp=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/kernel_rowbuf_ctrl.md
Name: kernel_rowbuf_ctrl

Overview:
- Sequencing controller for a KERNEL_SIZE x KERNEL_SIZE windowing datapath built from KERNEL_SIZE-1 single-port row buffers.
- Parses the typed dtype stream, generates the shared column address and a per-buffer one-hot write enable, and rotates a write pointer so that only one buffer is written per row (pointer muxing instead of buffer-to-buffer copy).
- Produces kernel shift/valid qualifiers, border-trimmed output framing, trimmed image dimensions and sticky protocol error flags.
- Sits between the stream source and the row-buffer/kernel-register datapath.

Parameters:
KERNEL_SIZE, 3, kernel edge length; NBUF = KERNEL_SIZE-1 row buffers; legal range 2..8.
NUM_COLS_WIDTH, 11, width of column address and counts.
MAX_COLS, 1288, row-buffer depth; pixel addresses are 0..MAX_COLS-1.
NUM_ROWS_WIDTH, 11, width of row counter.

Ports:
clk  in  1  clock.
resetb  in  1  synchronous active-low reset.
dvi  in  1  input data valid.
dtypei  in  `DTYPE_WIDTH  input data type.
clr_err  in  1  clears sticky error flags.
col_addr  out  NUM_COLS_WIDTH  row-buffer address for the current pixel (registered).
buf_we  out  NBUF  one-hot write enable (combinational from dvi/dtypei/state).
rd_base  out  3  index of oldest buffer; kernel row k reads buffer (rd_base+k) mod NBUF.
kernel_shift  out  1  pixel accepted this cycle; shift kernel registers (combinational).
dvo  out  1  registered output valid.
dtypeo  out  `DTYPE_WIDTH  registered dtypei.
out_cols  out  NUM_COLS_WIDTH  trimmed width of last frame.
out_rows  out  NUM_ROWS_WIDTH  trimmed height of last frame.
err_overflow  out  1  sticky: pixel at column >= MAX_COLS.
err_len  out  1  sticky: row length differs from row 0 of the frame.
err_proto  out  1  sticky: dtype sequence violation.

Behaviour:
- Reset (resetb low at clk edge): state IDLE; col_addr, wr_ptr, rd_base, row_cnt, row0_len, dvo, dtypeo, out_cols, out_rows and all err_* = 0. Reset mid-frame abandons the frame; the next frame proceeds normally.
- States: IDLE (outside frame), GAP (inside frame, between rows), ROW (inside row). Transitions occur only when dvi=1.
  IDLE --FRAME_START--> GAP; row_cnt=0, wr_ptr=0.
  GAP --ROW_START--> ROW; col_addr=0.
  ROW --ROW_END--> GAP; wr_ptr=(wr_ptr+1) mod NBUF; row_cnt+1, saturating at all-ones; on row 0, row0_len=col_addr; on later rows, col_addr!=row0_len sets err_len.
  GAP --FRAME_END--> IDLE; out_cols=max(row0_len-(KERNEL_SIZE-1),0); out_rows=max(row_cnt-(KERNEL_SIZE-1),0).
  FRAME_START in GAP or ROW: sets err_proto and restarts the frame as above.
  ROW_START in ROW: sets err_proto, col_addr=0; no pointer rotation, row not counted.
  Pixel outside ROW, ROW_END outside ROW, FRAME_END in ROW: set err_proto; token ignored. FRAME_END in ROW still returns to IDLE.
  Header dtypes: pass through in any state.
- Pixel = dvi && |(dtypei & `DTYPE_PIXEL_MASK) in ROW.
  - kernel_shift=1.
  - buf_we = one-hot(wr_ptr) only when col_addr < MAX_COLS; otherwise 0 and err_overflow set.
  - col_addr increments, saturating at MAX_COLS.
  - rd_base tracks wr_ptr: the read-before-write of the buffer being overwritten returns the oldest row.
- Framing, registered with 1-cycle latency relative to dvi; dtypeo <= dtypei every cycle.
  valid_row = row_cnt >= KERNEL_SIZE-1.
  valid_col = col_addr (pre-increment) >= KERNEL_SIZE-1.
  dvo = dvi gated by dtype: ROW_START/ROW_END give valid_row; pixel gives valid_row && valid_col; every other dtype, including illegal-but-ignored tokens, gives dvi.
  dvi=0 gives dvo=0.
- Errors: sticky until clr_err. A set and clr_err in the same cycle leaves the flag set.

Test Plan:
- K=3, frame 4 rows x 5 pixels -> exactly 6 pixel dvo pulses (rows 2-3, cols 2-4); ROW_START/END dvo only on rows 2,3; out_cols=3, out_rows=2; buf_we pattern per row 01,10,01,10; no errors.
- MAX_COLS=8, row of 10 pixels -> buf_we active on first 8 pixels only, col_addr sticks at 8, err_overflow=1; kernel_shift on all 10.
- Rows of lengths 5,5,4 -> err_len=1 at third ROW_END; out_cols still 3.
- Pixel in GAP, then ROW_START in ROW -> err_proto=1, col_addr reset to 0, wr_ptr unchanged; clr_err asserted with a new violation in the same cycle -> err_proto stays 1; clr_err alone -> 0.
- resetb low for 1 cycle mid-row (col_addr=3) -> all outputs 0 next cycle, state IDLE; a subsequent 3x3 frame yields 1 pixel dvo, out_cols=1, out_rows=1.
- FRAME_START mid-row -> err_proto=1, row_cnt=0, wr_ptr=0, frame restarts cleanly.
